// File: rtl/debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : N-channel push-button conditioner. Each channel has a 2-flop
//                synchroniser with optional polarity inversion, a counter-based
//                stability filter, press/release single-cycle pulses and an
//                optional auto-repeat pulse while the channel is held.
//  Ports       :
//    clk_i        in   1         system clock, rising edge
//    rst_i        in   1         asynchronous reset, active-low
//    btn_i        in   CHANNELS  raw asynchronous button inputs
//    level_o      out  CHANNELS  debounced pressed state (1 = pressed)
//    press_o      out  CHANNELS  1-cycle pulse when level_o rises
//    release_o    out  CHANNELS  1-cycle pulse when level_o falls
//    repeat_o     out  CHANNELS  1-cycle auto-repeat pulse (0 when REPEAT_EN=0)
//    any_press_o  out  1         OR of press_o, aligned with press_o
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o,
    output logic                any_press_o
);

    // ------------------------------------------------------------------------
    // Configuration range checks (elaboration time)
    // ------------------------------------------------------------------------
    if (CHANNELS < 1) begin : g_err_channels
        $error("debounce_multi: CHANNELS must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 30) begin : g_err_cnt_w
        $error("debounce_multi: CNT_W must be in 1..30");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_err_stable
        $error("debounce_multi: STABLE_CYCLES out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > (2**CNT_W) - 1) begin : g_err_delay
        $error("debounce_multi: REPEAT_DELAY out of range");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > (2**CNT_W) - 1) begin : g_err_period
        $error("debounce_multi: REPEAT_PERIOD out of range");
    end

    localparam logic [CHANNELS-1:0] c_inv       = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]    c_stab_last = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] r_s0;
    logic [CHANNELS-1:0] r_s1;
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_press;
    logic [CHANNELS-1:0] r_release;
    logic                r_any_press;
    logic [CHANNELS-1:0] w_toggle;
    logic [CHANNELS-1:0] w_repeat;

    // ------------------------------------------------------------------------
    // Synchroniser: polarity is normalised before the first flop so that
    // everything downstream sees 1 = pressed, and reset means "released".
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else begin
            r_s0 <= btn_i ^ c_inv;
            r_s1 <= r_s0;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel stability filter
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [CNT_W-1:0] r_stab_cnt;

        // Level flips once the differing value has been seen for
        // STABLE_CYCLES consecutive edges; any return to the current level
        // restarts the count.
        assign w_toggle[gi] = (r_s1[gi] != r_level[gi]) && (r_stab_cnt == c_stab_last);

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                r_stab_cnt <= '0;
            end else if (r_s1[gi] == r_level[gi] || w_toggle[gi]) begin
                r_stab_cnt <= '0;
            end else begin
                r_stab_cnt <= r_stab_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Debounced level and edge pulses, registered together so the pulse is
    // high exactly in the first cycle of the new level.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_level     <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_any_press <= 1'b0;
        end else begin
            r_level     <= r_level ^ w_toggle;
            r_press     <= w_toggle & ~r_level;
            r_release   <= w_toggle & r_level;
            r_any_press <= |(w_toggle & ~r_level);
        end
    end

    // ------------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------------
    if (REPEAT_EN != 0) begin : g_repeat
        localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);

        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rep_chan
            logic [CNT_W-1:0] r_rep_cnt;
            logic             r_rep_first;  // still waiting for the first repeat
            logic             r_rep;
            logic [CNT_W-1:0] w_rep_limit;

            assign w_rep_limit    = r_rep_first ? c_delay_last : c_period_last;
            assign w_repeat[gi]   = r_rep;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                    r_rep       <= 1'b0;
                end else if (w_toggle[gi] || !r_level[gi]) begin
                    // A level change (press or release) restarts the
                    // sequence; the release edge itself never repeats.
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                    r_rep       <= 1'b0;
                end else if (r_rep_cnt == w_rep_limit) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b0;
                    r_rep       <= 1'b1;
                end else begin
                    r_rep_cnt   <= r_rep_cnt + CNT_W'(1);
                    r_rep       <= 1'b0;
                end
            end
        end
    end else begin : g_no_repeat
        assign w_repeat = '0;
    end

    assign level_o     = r_level;
    assign press_o     = r_press;
    assign release_o   = r_release;
    assign repeat_o    = w_repeat;
    assign any_press_o = r_any_press;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Directed self-checking bench for debounce_multi with
//                STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
//                Expected outputs per cycle are derived from the hand-computed
//                press/release edges of each channel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_multi;

    localparam int NEVER = 1 << 28;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] btn;
    logic [3:0] level_o, press_o, release_o, repeat_o;
    logic       any_press_o;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int exp_p [4];
    int exp_r [4];

    always #5 clk_i = ~clk_i;

    debounce_multi #(
        .CHANNELS     (4),
        .ACTIVE_LOW   (1),
        .CNT_W        (8),
        .STABLE_CYCLES(4),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .btn_i      (btn),
        .level_o    (level_o),
        .press_o    (press_o),
        .release_o  (release_o),
        .repeat_o   (repeat_o),
        .any_press_o(any_press_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    function automatic logic [16:0] observed();
        return {level_o, press_o, release_o, repeat_o, any_press_o};
    endfunction

    // Expected outputs after edge k, given the press edge P and release edge R
    // of every channel: repeats at P+10, P+13, ... strictly before R.
    function automatic logic [16:0] expected(int k);
        logic [3:0] lv, pr, rl, rp;
        lv = '0; pr = '0; rl = '0; rp = '0;
        for (int ch = 0; ch < 4; ch++) begin
            lv[ch] = (k >= exp_p[ch]) && (k < exp_r[ch]);
            pr[ch] = (k == exp_p[ch]);
            rl[ch] = (k == exp_r[ch]);
            rp[ch] = (k >= exp_p[ch] + 10) && (k < exp_r[ch]) && (((k - exp_p[ch] - 10) % 3) == 0);
        end
        return {lv, pr, rl, rp, |pr};
    endfunction

    task automatic clear_expect();
        for (int ch = 0; ch < 4; ch++) begin
            exp_p[ch] = NEVER;
            exp_r[ch] = NEVER;
        end
    endtask

    task automatic test_reset();
        logic [16:0] o;
        clear_expect();
        rst_i = 1'b0;
        btn   = 4'b0000;
        for (int n = 1; n <= 5; n++) begin
            step();
            o = observed();
            vectors++;
            if (o !== 17'h0) begin
                miscompares++;
                $display("FAIL reset_hold n=%0d: got %h want %h", n, o, 17'h0);
            end
        end
        btn   = 4'b1111;
        rst_i = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            step();
            o = observed();
            vectors++;
            if (o !== 17'h0) begin
                miscompares++;
                $display("FAIL reset_release n=%0d: got %h want %h", n, o, 17'h0);
            end
        end
    endtask

    task automatic test_clean_press();
        int c0;
        logic [16:0] o, e;
        clear_expect();
        c0 = cyc;
        exp_p[0] = c0 + 6;
        exp_r[0] = c0 + 26;
        btn[0] = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            step();
            if (n == 20) btn[0] = 1'b1;
            o = observed();
            e = expected(cyc);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL clean_press n=%0d: got %h want %h", n, o, e);
            end
        end
    endtask

    task automatic test_bounce();
        int c0;
        logic [16:0] o, e;
        clear_expect();
        c0 = cyc;
        exp_p[1] = c0 + 26;
        exp_r[1] = c0 + 36;  // coincides with the first repeat slot
        btn[1] = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            step();
            if (n < 20)       btn[1] = ((n / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else if (n == 20) btn[1] = 1'b0;
            else if (n == 30) btn[1] = 1'b1;
            o = observed();
            e = expected(cyc);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL bounce n=%0d: got %h want %h", n, o, e);
            end
        end
    endtask

    task automatic test_repeat();
        int c0;
        logic [16:0] o, e;
        clear_expect();
        c0 = cyc;
        exp_p[2] = c0 + 6;
        exp_r[2] = c0 + 46;
        btn[2] = 1'b0;
        for (int n = 1; n <= 55; n++) begin
            step();
            if (n == 40) btn[2] = 1'b1;
            o = observed();
            e = expected(cyc);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL repeat n=%0d: got %h want %h", n, o, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        logic [16:0] o, e;
        clear_expect();
        c0 = cyc;
        for (int ch = 0; ch < 4; ch++) begin
            exp_p[ch] = c0 + 6;
            exp_r[ch] = c0 + 21;
        end
        btn = 4'b0000;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 15) btn = 4'b1111;
            o = observed();
            e = expected(cyc);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL simultaneous n=%0d: got %h want %h", n, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int c0;
        logic [16:0] o, e;
        clear_expect();
        c0 = cyc;
        exp_p[0] = c0 + 6;
        btn[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            o = observed();
            e = expected(cyc);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid_hold_pre n=%0d: got %h want %h", n, o, e);
            end
        end
        rst_i = 1'b0;
        #1;
        o = observed();
        vectors++;
        if (o !== 17'h0) begin
            miscompares++;
            $display("FAIL mid_hold_assert: got %h want %h", o, 17'h0);
        end
        for (int n = 9; n <= 11; n++) begin
            step();
            o = observed();
            vectors++;
            if (o !== 17'h0) begin
                miscompares++;
                $display("FAIL mid_hold_in_reset n=%0d: got %h want %h", n, o, 17'h0);
            end
        end
        rst_i = 1'b1;
        exp_p[0] = c0 + 17;
        exp_r[0] = c0 + 36;
        for (int n = 12; n <= 45; n++) begin
            step();
            if (n == 30) btn[0] = 1'b1;
            o = observed();
            e = expected(cyc);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid_hold_post n=%0d: got %h want %h", n, o, e);
            end
        end
    endtask

    initial begin
        rst_i = 1'b0;
        btn   = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
